// File: rtl/cpu_regfile_seq_if.sv
// cpu_regfile_seq_if: control/data bundle between cpu_control (master) and the register file sequencer (slave).
interface cpu_regfile_seq_if #(
    parameter int NUM_REGS = 14,
    parameter int DATA_W   = 8,
    parameter int T_PER_M  = 4
);
    localparam int TW = $clog2(T_PER_M);
    localparam int IW = $clog2(NUM_REGS);
    localparam int PW = $clog2(NUM_REGS / 2);
    logic              stall;
    logic [TW-1:0]     t_cycle;
    logic              m_commit;
    logic [IW-1:0]     rd1_idx, rd2_idx;
    logic [DATA_W-1:0] rd1_data, rd2_data;
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        inc_op;
    logic [PW-1:0]     inc_pair;
    logic [2*DATA_W-1:0] inc_in, inc_out;
    logic              pc_load_inc;
    logic              flag_we;
    logic [3:0]        flag_mask, flag_data, flags;
    logic [2*DATA_W-1:0] pc;
    modport master (
        output stall, rd1_idx, rd2_idx, wr_en, wr_idx, wr_data, inc_op, inc_pair,
               pc_load_inc, flag_we, flag_mask, flag_data,
        input  t_cycle, m_commit, rd1_data, rd2_data, inc_in, inc_out, flags, pc
    );
    modport slave (
        input  stall, rd1_idx, rd2_idx, wr_en, wr_idx, wr_data, inc_op, inc_pair,
               pc_load_inc, flag_we, flag_mask, flag_data,
        output t_cycle, m_commit, rd1_data, rd2_data, inc_in, inc_out, flags, pc
    );
endinterface

// File: rtl/cpu_regfile_seq.sv
// cpu_regfile_seq: SM83-style register file, pair incrementer and T-cycle sequencer committing on the last phase.
// Define REGFILE_BYPASS_EN to forward same-cycle port/incrementer writes to the read ports.
module cpu_regfile_seq #(
    parameter int NUM_REGS = 14,
    parameter int DATA_W   = 8,
    parameter int T_PER_M  = 4,
    parameter int PC_PAIR  = 6,
    parameter int FLAG_REG = 6,
    parameter logic [2*DATA_W-1:0] PC_RESET = '0
) (
    input logic clk,
    input logic reset_n,
    cpu_regfile_seq_if.slave bus
);
    localparam int TW = $clog2(T_PER_M);
    localparam int IW = $clog2(NUM_REGS);
    localparam int PW = $clog2(NUM_REGS / 2);
    localparam int AW = 2 * DATA_W;
    localparam logic [DATA_W-1:0] FMASK = ~DATA_W'((1 << (DATA_W - 4)) - 1);
    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [DATA_W-1:0] nxt     [NUM_REGS];
    logic [DATA_W-1:0] fwd_val [NUM_REGS];
    logic              fwd_en  [NUM_REGS];
    logic [TW-1:0]     t;
    logic              last, commit, pair_ok, inc_wb;
    logic [AW-1:0]     inc_in, inc_out;
    logic [3:0]        f_new;
    logic [DATA_W-1:0] f_byte;
    logic [IW-1:0]     ridx [2];
    logic [DATA_W-1:0] rdat [2];
    assign last    = t == TW'(T_PER_M - 1);
    assign commit  = last && !bus.stall && reset_n;
    assign pair_ok = int'(bus.inc_pair) < NUM_REGS / 2;
    assign inc_in  = pair_ok ? {regs[{bus.inc_pair, 1'b0}], regs[{bus.inc_pair, 1'b1}]} : '0;
    assign inc_out = bus.inc_op == 2'd2 ? inc_in - AW'(1) : bus.inc_op == 2'd0 ? inc_in : inc_in + AW'(1);
    assign inc_wb  = pair_ok && (bus.inc_op == 2'd1 || bus.inc_op == 2'd2);
    assign f_new   = (bus.flag_mask & bus.flag_data) | (~bus.flag_mask & bus.flags);
    assign f_byte  = DATA_W'(f_new) << (DATA_W - 4);
    // PC load and pair writeback both carry inc_out, so they share one top-priority path
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam bit IS_PC = (g / 2) == PC_PAIR;
        logic              inc_hit, wr_hit;
        logic [DATA_W-1:0] raw;
        assign inc_hit    = (bus.pc_load_inc && IS_PC) || (inc_wb && bus.inc_pair == PW'(g / 2));
        assign wr_hit     = bus.wr_en && bus.wr_idx == IW'(g);
        assign raw        = inc_hit ? ((g % 2 == 0) ? inc_out[AW-1 -: DATA_W] : inc_out[DATA_W-1:0]) : bus.wr_data;
        assign fwd_en[g]  = inc_hit || wr_hit;
        assign fwd_val[g] = (g == FLAG_REG) ? raw & FMASK : raw;
        assign nxt[g]     = fwd_en[g] ? fwd_val[g] : (bus.flag_we && g == FLAG_REG) ? f_byte : regs[g];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == 2 * PC_PAIR) ? PC_RESET[AW-1 -: DATA_W] :
                           (i == 2 * PC_PAIR + 1) ? PC_RESET[DATA_W-1:0] : '0;
        end else begin
            if (!bus.stall) t <= last ? '0 : t + TW'(1);
            if (commit)
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= nxt[i];
        end
    end
    assign ridx[0] = bus.rd1_idx;
    assign ridx[1] = bus.rd2_idx;
    for (genvar r = 0; r < 2; r++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
        assign rdat[r] = int'(ridx[r]) >= NUM_REGS ? '0 : fwd_en[ridx[r]] ? fwd_val[ridx[r]] : regs[ridx[r]];
`else
        assign rdat[r] = int'(ridx[r]) >= NUM_REGS ? '0 : regs[ridx[r]];
`endif
    end
    assign bus.rd1_data = rdat[0];
    assign bus.rd2_data = rdat[1];
    assign bus.t_cycle  = t;
    assign bus.m_commit = commit;
    assign bus.inc_in   = inc_in;
    assign bus.inc_out  = inc_out;
    assign bus.flags    = regs[FLAG_REG][DATA_W-1 -: 4];
    assign bus.pc       = {regs[2*PC_PAIR], regs[2*PC_PAIR+1]};
endmodule

// File: tb/tb_cpu_regfile_seq.sv
// tb_cpu_regfile_seq: directed checks of sequencing, incrementer, write priority, flags and read forwarding.
module tb_cpu_regfile_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   commits;
    int   exp_t [8] = '{0, 1, 1, 1, 1, 2, 3, 0};
    cpu_regfile_seq_if #(.NUM_REGS(14), .DATA_W(8), .T_PER_M(4)) bus ();
    cpu_regfile_seq #(.PC_RESET(16'h0100)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    // advance through the next commit edge, then drop all write requests
    task automatic run_to_commit();
        int k = 0;
        while (bus.m_commit !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        assert (bus.m_commit === 1'b1) else begin
            n_err++;
            $error("FAIL commit_wait: m_commit=%b expected 1", bus.m_commit);
        end
        @(negedge clk);
        bus.wr_en = 0; bus.flag_we = 0; bus.pc_load_inc = 0; bus.inc_op = 0;
    endtask
    task automatic wr(input int idx, input int data);
        bus.wr_en = 1; bus.wr_idx = 4'(idx); bus.wr_data = 8'(data);
        run_to_commit();
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.stall = 0; bus.rd1_idx = 0; bus.rd2_idx = 0; bus.wr_en = 0; bus.wr_idx = 0;
        bus.wr_data = 0; bus.inc_op = 0; bus.inc_pair = 0; bus.pc_load_inc = 0;
        bus.flag_we = 0; bus.flag_mask = 0; bus.flag_data = 0;
        @(negedge clk);
        chk("rst_pc", bus.pc, 32'h0100);
        chk("rst_t", bus.t_cycle, 0);
        chk("rst_commit", bus.m_commit, 0);
        chk("rst_reg0", bus.rd1_data, 0);
        chk("rst_flags", bus.flags, 0);
        reset_n = 1;
        commits = 0;
        for (int i = 0; i < 8; i++) begin
            chk("t_seq", bus.t_cycle, exp_t[i]);
            commits += int'(bus.m_commit);
            bus.stall = (i >= 1 && i <= 3);
            @(negedge clk);
        end
        chk("commit_pulses", commits, 1);
        bus.stall = 0;
        wr(0, 8'h33);
        chk("wr_reg0", bus.rd1_data, 8'h33);
        cyc(2);
        chk("t_mid", bus.t_cycle, 2);
        bus.wr_en = 1; bus.wr_idx = 1; bus.wr_data = 8'h44;
        #2 reset_n = 0;
        #1;
        chk("mid_rst_t", bus.t_cycle, 0);
        chk("mid_rst_pc", bus.pc, 32'h0100);
        chk("mid_rst_commit", bus.m_commit, 0);
        chk("mid_rst_reg0", bus.rd1_data, 0);
        bus.wr_en = 0;
        @(negedge clk);
        reset_n = 1;
        bus.rd2_idx = 1;
        chk("pending_dropped", bus.rd2_data, 0);
        bus.pc_load_inc = 1; bus.inc_pair = 6; bus.inc_op = 3;
        cyc(3);
        chk("last_commit", bus.m_commit, 1);
        bus.stall = 1;
        #1 chk("stall_last_commit", bus.m_commit, 0);
        cyc(2);
        chk("stall_last_t", bus.t_cycle, 3);
        chk("stall_last_pc", bus.pc, 32'h0100);
        bus.stall = 0;
        #1 chk("unstall_commit", bus.m_commit, 1);
        @(negedge clk);
        chk("late_commit_pc", bus.pc, 32'h0101);
        chk("late_commit_t", bus.t_cycle, 0);
        bus.pc_load_inc = 0; bus.inc_op = 0;
        bus.inc_pair = 2; bus.inc_op = 2;
        #1 chk("dec_in", bus.inc_in, 0);
        chk("dec_out", bus.inc_out, 32'hFFFF);
        run_to_commit();
        chk("hl_ffff", bus.inc_in, 32'hFFFF);
        bus.rd1_idx = 4; bus.rd2_idx = 5;
        #1 chk("h_ff", bus.rd1_data, 8'hFF);
        chk("l_ff", bus.rd2_data, 8'hFF);
        bus.inc_op = 1;
        #1 chk("inc_wrap_out", bus.inc_out, 0);
        run_to_commit();
        chk("hl_0000", bus.inc_in, 0);
        bus.inc_op = 3;
        #1 chk("op3_out", bus.inc_out, 1);
        run_to_commit();
        chk("op3_hl", bus.inc_in, 0);
        bus.inc_op = 1; bus.wr_en = 1; bus.wr_idx = 5; bus.wr_data = 8'h77;
        run_to_commit();
        chk("inc_beats_wr", bus.inc_in, 32'h0001);
        bus.inc_pair = 7; bus.inc_op = 1;
        #1 chk("oor_pair_in", bus.inc_in, 0);
        chk("oor_pair_out", bus.inc_out, 1);
        run_to_commit();
        chk("oor_pair_pc", bus.pc, 32'h0101);
        bus.inc_pair = 2;
        #1 chk("oor_pair_hl", bus.inc_in, 32'h0001);
        bus.rd1_idx = 14;
        wr(14, 8'hEE);
        chk("oor_rd", bus.rd1_data, 0);
        wr(12, 8'h12);
        wr(13, 8'h34);
        chk("pc_1234", bus.pc, 32'h1234);
        bus.wr_en = 1; bus.wr_idx = 13; bus.wr_data = 8'hAA;
        bus.pc_load_inc = 1; bus.inc_pair = 6; bus.inc_op = 3;
        #1 chk("pc_inc_out", bus.inc_out, 32'h1235);
        run_to_commit();
        chk("pc_beats_wr", bus.pc, 32'h1235);
        bus.rd1_idx = 6;
        bus.flag_we = 1; bus.flag_mask = 4'hF; bus.flag_data = 4'hF;
        run_to_commit();
        chk("flags_f", bus.flags, 4'hF);
        chk("freg_f0", bus.rd1_data, 8'hF0);
        bus.flag_we = 1; bus.flag_mask = 4'b0101; bus.flag_data = 4'b0000;
        run_to_commit();
        chk("flags_a", bus.flags, 4'hA);
        chk("freg_a0", bus.rd1_data, 8'hA0);
        wr(6, 8'hFF);
        chk("freg_low0", bus.rd1_data, 8'hF0);
        bus.flag_we = 1; bus.flag_mask = 4'hF; bus.flag_data = 4'hF;
        wr(6, 8'h00);
        chk("wr_beats_flag", bus.flags, 0);
        cyc(1);
        chk("t_phase1", bus.t_cycle, 1);
        bus.rd1_idx = 7; bus.wr_en = 1; bus.wr_idx = 7; bus.wr_data = 8'h5A;
`ifdef REGFILE_BYPASS_EN
        #1 chk("bypass_rd", bus.rd1_data, 8'h5A);
`else
        #1 chk("nobypass_rd", bus.rd1_data, 8'h00);
`endif
        run_to_commit();
        chk("post_commit_rd", bus.rd1_data, 8'h5A);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
